bp_be_fp_to_int_iter: RTL

- Floating-point-to-integer side of the FP auxiliary datapath; the opposite direction of the int-to-FP / FP-result path.
- Accepts a raw IEEE operand: double, or NaN-boxed single in [31:0].
- Produces an RV64 integer-register result for FCVT.{W,WU,L,LU}.{S,D}, FMV.X.{W,D} and FCLASS.
- Multicycle: right-shift normalisation is iterative; valid/ready in, valid/yumi out.

---
 rtl/bp_be_pkg.sv | 100 ++++++++++
 rtl/bp_be_f2i_round.sv | 73 +++++++
 rtl/bp_be_fp_to_int_iter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// Shared types, constants and helpers for the FP-to-integer conversion unit.
// Also holds the fclass bit positions and the integer saturation values.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_f2i_s      = 2'd0,
        e_f2i_u      = 2'd1,
        e_f2i_fmv    = 2'd2,
        e_f2i_fclass = 2'd3
    } bp_be_f2i_op_e;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_shift = 2'd1,
        e_round = 2'd2,
        e_done  = 2'd3
    } bp_be_f2i_state_e;

    typedef enum logic {
        e_pr_single = 1'b0,
        e_pr_double = 1'b1
    } bp_be_fp_pr_e;

    typedef enum logic [2:0] {
        e_rne = 3'd0,
        e_rtz = 3'd1,
        e_rdn = 3'd2,
        e_rup = 3'd3,
        e_rmm = 3'd4,
        e_dyn = 3'd7
    } rv64_frm_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } rv64_fflags_s;

    localparam int unsigned fclass_neg_inf_c   = 0;
    localparam int unsigned fclass_neg_norm_c  = 1;
    localparam int unsigned fclass_neg_sub_c   = 2;
    localparam int unsigned fclass_neg_zero_c  = 3;
    localparam int unsigned fclass_pos_zero_c  = 4;
    localparam int unsigned fclass_pos_sub_c   = 5;
    localparam int unsigned fclass_pos_norm_c  = 6;
    localparam int unsigned fclass_pos_inf_c   = 7;
    localparam int unsigned fclass_snan_c      = 8;
    localparam int unsigned fclass_qnan_c      = 9;

    localparam logic [63:0] f2i_w_smax_c = 64'h0000_0000_7FFF_FFFF;
    localparam logic [63:0] f2i_w_smin_c = 64'hFFFF_FFFF_8000_0000;
    localparam logic [63:0] f2i_l_smax_c = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] f2i_l_smin_c = 64'h8000_0000_0000_0000;
    localparam logic [63:0] f2i_umax_c   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] f2i_umin_c   = 64'h0000_0000_0000_0000;

    // Right shift of {mag,g} by k; returns {mag', g', sticky'}.
    function automatic logic [66:0] f2i_rshift(input logic [64:0] mag,
                                               input logic        g,
                                               input logic        s,
                                               input logic [6:0]  k);
        logic [65:0] ext;
        logic [65:0] mask;
        logic [65:0] shifted;
        ext     = {mag, g};
        shifted = ext >> k;
        mask    = (66'd1 << k) - 66'd1;
        return {shifted, s | (|(ext & mask))};
    endfunction

    function automatic logic [9:0] f2i_fclass(input logic sign,
                                              input logic exp_zero,
                                              input logic exp_ones,
                                              input logic frac_zero,
                                              input logic quiet);
        logic [9:0] c;
        c = 10'd0;
        if (exp_ones) begin
            if (frac_zero) begin
                c[sign ? fclass_neg_inf_c : fclass_pos_inf_c] = 1'b1;
            end else if (quiet) begin
                c[fclass_qnan_c] = 1'b1;
            end else begin
                c[fclass_snan_c] = 1'b1;
            end
        end else if (exp_zero) begin
            if (frac_zero) begin
                c[sign ? fclass_neg_zero_c : fclass_pos_zero_c] = 1'b1;
            end else begin
                c[sign ? fclass_neg_sub_c : fclass_pos_sub_c] = 1'b1;
            end
        end else begin
            c[sign ? fclass_neg_norm_c : fclass_pos_norm_c] = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/bp_be_f2i_round.sv
// Combinational rounding, range check and saturation for FP-to-integer results.
module bp_be_f2i_round
    import bp_be_pkg::*;
(
    input  logic [64:0]  mag_i,
    input  logic         g_i,
    input  logic         s_i,
    input  logic         sign_i,
    input  rv64_frm_e    rm_i,
    input  bp_be_fp_pr_e opr_i,
    input  logic         signed_i,
    input  logic         ovf_i,
    input  logic         nan_i,
    output logic [63:0]  o,
    output rv64_fflags_s eflags_o
);

    logic        w_inc;
    logic [64:0] w_rnd;
    logic [64:0] w_pos_lim;
    logic [64:0] w_neg_lim;
    logic [63:0] w_max;
    logic [63:0] w_min;
    logic [63:0] w_res;
    logic        w_word;

    // Round-increment decision, limits, saturation and final sign-extension.
    always_comb begin
        w_word = (opr_i == e_pr_single);
        case (rm_i)
            e_rne:   w_inc = g_i & (s_i | mag_i[0]);
            e_rtz:   w_inc = 1'b0;
            e_rdn:   w_inc = sign_i & (g_i | s_i);
            e_rup:   w_inc = ~sign_i & (g_i | s_i);
            e_rmm:   w_inc = g_i;
            default: w_inc = 1'b0;
        endcase
        w_rnd = mag_i + {64'd0, w_inc};

        if (signed_i) begin
            w_pos_lim = w_word ? 65'h0_0000_0000_7FFF_FFFF : 65'h0_7FFF_FFFF_FFFF_FFFF;
            w_neg_lim = w_word ? 65'h0_0000_0000_8000_0000 : 65'h0_8000_0000_0000_0000;
            w_max     = w_word ? f2i_w_smax_c : f2i_l_smax_c;
            w_min     = w_word ? f2i_w_smin_c : f2i_l_smin_c;
        end else begin
            w_pos_lim = w_word ? 65'h0_0000_0000_FFFF_FFFF : 65'h0_FFFF_FFFF_FFFF_FFFF;
            w_neg_lim = 65'h0_0000_0000_0000_0000;
            w_max     = f2i_umax_c;
            w_min     = f2i_umin_c;
        end

        eflags_o = rv64_fflags_s'(5'b0);
        if (nan_i) begin
            w_res       = w_max;
            eflags_o.nv = 1'b1;
        end else if (ovf_i) begin
            w_res       = sign_i ? w_min : w_max;
            eflags_o.nv = 1'b1;
        end else if (sign_i && (w_rnd > w_neg_lim)) begin
            w_res       = w_min;
            eflags_o.nv = 1'b1;
        end else if (!sign_i && (w_rnd > w_pos_lim)) begin
            w_res       = w_max;
            eflags_o.nv = 1'b1;
        end else begin
            w_res       = sign_i ? (64'd0 - w_rnd[63:0]) : w_rnd[63:0];
            eflags_o.nx = g_i | s_i;
        end

        o = w_word ? {{32{w_res[31]}}, w_res[31:0]} : w_res;
    end

endmodule

// File: rtl/bp_be_fp_to_int_iter.sv
// Multicycle FP-to-integer unit: FCVT.{W,WU,L,LU}.{S,D}, FMV.X.{W,D}, FCLASS.
// Define BP_BE_F2I_SINGLE_CYCLE_SHIFT_EN to do the whole right shift at accept.
module bp_be_fp_to_int_iter
    import bp_be_pkg::*;
#(
    parameter int shift_step_p = 8
)
(
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          v_i,
    output logic          ready_o,
    input  logic [63:0]   a_i,
    input  bp_be_f2i_op_e op_i,
    input  bp_be_fp_pr_e  ipr_i,
    input  bp_be_fp_pr_e  opr_i,
    input  rv64_frm_e     rm_i,
    output logic          v_o,
    input  logic          yumi_i,
    output logic [63:0]   o,
    output rv64_fflags_s  eflags_o
);

    localparam logic [6:0] step_lp = 7'(shift_step_p);

    bp_be_f2i_state_e r_state, w_state_n;
    logic [64:0]   r_mag, w_mag_n;
    logic          r_g, w_g_n, r_s, w_s_n;
    logic [5:0]    r_rem, w_rem_n;
    logic          r_sign, w_sign_n, r_ovf, w_ovf_n, r_nan, w_nan_n;
    bp_be_f2i_op_e r_op, w_op_n;
    bp_be_fp_pr_e  r_opr, w_opr_n;
    rv64_frm_e     r_rm, w_rm_n;
    logic [63:0]   r_o, w_o_n;
    rv64_fflags_s  r_eflags, w_flags_n;

    logic          w_is_d, w_sign, w_exp_zero, w_exp_ones, w_frac_zero, w_quiet;
    logic          w_nan, w_inf;
    logic signed [11:0] w_exp;
    logic [51:0]   w_frac;
    logic [52:0]   w_sig;
    logic [3:0]    w_lsh;
    logic [5:0]    w_rem;
    logic [6:0]    w_k;
    logic [66:0]   w_shr;
    logic [63:0]   w_rnd_o;
    rv64_fflags_s  w_rnd_flags;

    // Unpack the raw operand into sign, unbiased exponent and 53-bit significand.
    always_comb begin
        w_is_d = (ipr_i == e_pr_double);
        if (w_is_d) begin
            w_sign      = a_i[63];
            w_exp_zero  = (a_i[62:52] == 11'd0);
            w_exp_ones  = (a_i[62:52] == 11'h7FF);
            w_frac_zero = (a_i[51:0] == 52'd0);
            w_quiet     = a_i[51];
            w_exp       = $signed({1'b0, a_i[62:52]}) - 12'sd1023;
            w_frac      = a_i[51:0];
        end else begin
            w_sign      = a_i[31];
            w_exp_zero  = (a_i[30:23] == 8'd0);
            w_exp_ones  = (a_i[30:23] == 8'hFF);
            w_frac_zero = (a_i[22:0] == 23'd0);
            w_quiet     = a_i[22];
            w_exp       = $signed({4'd0, a_i[30:23]}) - 12'sd127;
            w_frac      = {a_i[22:0], 29'd0};
        end
        if (w_exp_zero) begin
            w_exp = -12'sd1023;
        end else begin
            w_exp = w_exp;
        end
        w_sig = {~w_exp_zero, w_frac};
        w_nan = w_exp_ones & ~w_frac_zero;
        w_inf = w_exp_ones & w_frac_zero;
        // Low bits suffice: exp-52 lies in 0..11 and 52-exp in 1..54 where used.
        w_lsh = w_exp[3:0] - 4'd4;
        if (w_exp < -12'sd2) begin
            w_rem = 6'd54;
        end else begin
            w_rem = 6'd52 - w_exp[5:0];
        end
    end

    // Next-state and next-datapath logic for the conversion FSM.
    always_comb begin
        w_state_n = r_state;
        w_mag_n   = r_mag;
        w_g_n     = r_g;
        w_s_n     = r_s;
        w_rem_n   = r_rem;
        w_sign_n  = r_sign;
        w_ovf_n   = r_ovf;
        w_nan_n   = r_nan;
        w_op_n    = r_op;
        w_opr_n   = r_opr;
        w_rm_n    = r_rm;
        w_o_n     = r_o;
        w_flags_n = r_eflags;
        w_k       = 7'd0;
        w_shr     = 67'd0;
        case (r_state)
            e_idle: begin
                if (v_i) begin
                    w_sign_n = w_sign;
                    w_op_n   = op_i;
                    w_opr_n  = opr_i;
                    w_rm_n   = rm_i;
                    w_nan_n  = w_nan;
                    w_ovf_n  = 1'b0;
                    w_g_n    = 1'b0;
                    w_s_n    = 1'b0;
                    w_rem_n  = 6'd0;
                    w_mag_n  = {12'd0, w_sig};
                    case (op_i)
                        e_f2i_fmv: begin
                            w_o_n     = w_is_d ? a_i : {{32{a_i[31]}}, a_i[31:0]};
                            w_flags_n = rv64_fflags_s'(5'b0);
                            w_state_n = e_done;
                        end
                        e_f2i_fclass: begin
                            w_o_n     = {54'd0, f2i_fclass(w_sign, w_exp_zero, w_exp_ones,
                                                           w_frac_zero, w_quiet)};
                            w_flags_n = rv64_fflags_s'(5'b0);
                            w_state_n = e_done;
                        end
                        default: begin
                            if (w_nan || w_inf || (w_exp >= 12'sd64)) begin
                                w_ovf_n   = 1'b1;
                                w_state_n = e_round;
                            end else if (w_exp >= 12'sd52) begin
                                w_mag_n   = {12'd0, w_sig} << w_lsh;
                                w_state_n = e_round;
                            end else begin
`ifdef BP_BE_F2I_SINGLE_CYCLE_SHIFT_EN
                                w_k       = {1'b0, w_rem};
                                w_shr     = f2i_rshift({12'd0, w_sig}, 1'b0, 1'b0, w_k);
                                w_mag_n   = w_shr[66:2];
                                w_g_n     = w_shr[1];
                                w_s_n     = w_shr[0];
                                w_state_n = e_round;
`else
                                w_rem_n   = w_rem;
                                w_state_n = e_shift;
`endif
                            end
                        end
                    endcase
                end else begin
                    w_state_n = e_idle;
                end
            end
            e_shift: begin
`ifdef BP_BE_F2I_SINGLE_CYCLE_SHIFT_EN
                w_state_n = e_idle;
`else
                w_k     = ({1'b0, r_rem} > step_lp) ? step_lp : {1'b0, r_rem};
                w_shr   = f2i_rshift(r_mag, r_g, r_s, w_k);
                w_mag_n = w_shr[66:2];
                w_g_n   = w_shr[1];
                w_s_n   = w_shr[0];
                w_rem_n = r_rem - w_k[5:0];
                if (w_rem_n == 6'd0) begin
                    w_state_n = e_round;
                end else begin
                    w_state_n = e_shift;
                end
`endif
            end
            e_round: begin
                w_o_n     = w_rnd_o;
                w_flags_n = w_rnd_flags;
                w_state_n = e_done;
            end
            e_done: begin
                if (yumi_i) begin
                    w_state_n = e_idle;
                end else begin
                    w_state_n = e_done;
                end
            end
            default: w_state_n = e_idle;
        endcase
    end

    bp_be_f2i_round u_round (
        .mag_i    (r_mag),
        .g_i      (r_g),
        .s_i      (r_s),
        .sign_i   (r_sign),
        .rm_i     (r_rm),
        .opr_i    (r_opr),
        .signed_i (r_op == e_f2i_s),
        .ovf_i    (r_ovf),
        .nan_i    (r_nan),
        .o        (w_rnd_o),
        .eflags_o (w_rnd_flags)
    );

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= e_idle;
            r_mag    <= 65'd0;
            r_g      <= 1'b0;
            r_s      <= 1'b0;
            r_rem    <= 6'd0;
            r_sign   <= 1'b0;
            r_ovf    <= 1'b0;
            r_nan    <= 1'b0;
            r_op     <= e_f2i_s;
            r_opr    <= e_pr_single;
            r_rm     <= e_rne;
            r_o      <= 64'd0;
            r_eflags <= rv64_fflags_s'(5'b0);
        end else begin
            r_state  <= w_state_n;
            r_mag    <= w_mag_n;
            r_g      <= w_g_n;
            r_s      <= w_s_n;
            r_rem    <= w_rem_n;
            r_sign   <= w_sign_n;
            r_ovf    <= w_ovf_n;
            r_nan    <= w_nan_n;
            r_op     <= w_op_n;
            r_opr    <= w_opr_n;
            r_rm     <= w_rm_n;
            r_o      <= w_o_n;
            r_eflags <= w_flags_n;
        end
    end

    assign ready_o  = (r_state == e_idle);
    assign v_o      = (r_state == e_done);
    assign o        = r_o;
    assign eflags_o = r_eflags;

endmodule
